// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: field widths, default inter-frame gap,
// arbiter state encoding and a counter-width helper.
package eth_pkg;

    localparam int ETH_LEN_W       = 16;
    localparam int ETH_BYTE_W      = 8;
    localparam int ETH_IFG_DEFAULT = 48;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_START     = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_DONE = 3'd3,
        ARB_GAP       = 3'd4
    } tx_arb_state_t;

    // Bits needed for a down-counter that is loaded with max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request scanning
// upward from last+1, wrapping modulo NUM_REQ, so the previous winner is
// considered last.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    int             cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan offsets from farthest to nearest so the nearest pending source wins.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        onehot   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand     = (int'(last) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                valid            = 1'b1;
                idx              = cand_idx;
                onehot           = '0;
                onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one eth_tx_framer between several frame
// sources. Grants one source at a time, launches the framer with its length,
// muxes its byte-read data to the framer and enforces an inter-frame gap.
// Optional build macro: TX_ARB_WDOG_EN enables a watchdog that aborts a frame
// (req_done with req_err=1) when the framer does not finish in WDOG_CYCLES.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no owner; pick next pending source, latch its length
// START      | one cycle; fr_start is registered out on the next cycle
// WAIT_BUSY  | waiting for framer to report busy (done also accepted)
// WAIT_DONE  | framer running; waiting for fr_done (or watchdog)
// GAP        | inter-frame holdoff down-counter before returning to IDLE
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int IFG_CYCLES  = ETH_IFG_DEFAULT,
    parameter int WDOG_CYCLES = 200000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ETH_LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*ETH_BYTE_W-1:0] req_rd_byte,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          req_err,
    output logic                          fr_start,
    output logic [ETH_LEN_W-1:0]          fr_len,
    input  logic [ETH_LEN_W-1:0]          fr_rd_idx,
    output logic [ETH_BYTE_W-1:0]         fr_rd_byte,
    input  logic                          fr_busy,
    input  logic                          fr_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = cnt_width(IFG_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES);
    // With no gap configured the arbiter returns straight to IDLE.
    localparam tx_arb_state_t GAP_ENTRY = (IFG_CYCLES == 0) ? ARB_IDLE : ARB_GAP;

    tx_arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic                   start_q, start_d;
    logic [ETH_LEN_W-1:0]   len_q, len_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [ETH_LEN_W-1:0]   pick_len;

`ifdef TX_ARB_WDOG_EN
    localparam int WD_W = cnt_width(WDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYCLES - 1);
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   err_q, err_d;
`endif

    // fr_rd_idx is consumed directly by the sources, not by the arbiter.
    logic unused_ok;
    assign unused_ok = ^{fr_rd_idx, (WDOG_CYCLES > 0)};

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign pick_len = req_len[ETH_LEN_W*int'(pick_idx) +: ETH_LEN_W];

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        last_d  = last_q;
        start_d = 1'b0;
        len_d   = len_q;
        gap_d   = gap_q;
`ifdef TX_ARB_WDOG_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    len_d  = pick_len;
                    last_d = pick_idx;
                    if (pick_len == '0) begin
                        // Nothing to send: complete at once, never touch the framer.
                        done_d  = pick_onehot;
                        gap_d   = GAP_LOAD;
                        state_d = GAP_ENTRY;
                    end else begin
                        grant_d = pick_onehot;
                        state_d = ARB_START;
                    end
                end
            end
            ARB_START: begin
                start_d = 1'b1;
                state_d = ARB_WAIT_BUSY;
`ifdef TX_ARB_WDOG_EN
                wd_d    = WD_LOAD;
`endif
            end
            ARB_WAIT_BUSY, ARB_WAIT_DONE: begin
                if (fr_done) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    gap_d   = GAP_LOAD;
                    state_d = GAP_ENTRY;
                end
`ifdef TX_ARB_WDOG_EN
                else if (wd_q == '0) begin
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    grant_d = '0;
                    gap_d   = GAP_LOAD;
                    state_d = GAP_ENTRY;
                end
`endif
                else begin
`ifdef TX_ARB_WDOG_EN
                    wd_d = wd_q - 1'b1;
`endif
                    if (state_q == ARB_WAIT_BUSY && fr_busy) begin
                        state_d = ARB_WAIT_DONE;
                    end
                end
            end
            ARB_GAP: begin
                if (gap_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and registered outputs; last resets to NUM_REQ-1 so source 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            start_q <= 1'b0;
            len_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            last_q  <= last_d;
            start_q <= start_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
        end
    end

`ifdef TX_ARB_WDOG_EN
    // Watchdog down-counter and abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign req_err = err_q;
`else
    assign req_err = 1'b0;
`endif

    // Byte mux from the owning source; last_q is the owner while a grant is held.
    always_comb begin
        fr_rd_byte = '0;
        if (|grant_q) begin
            fr_rd_byte = req_rd_byte[ETH_BYTE_W*int'(last_q) +: ETH_BYTE_W];
        end
    end

    assign req_grant = grant_q;
    assign req_done  = done_q;
    assign fr_start  = start_q;
    assign fr_len    = len_q;

endmodule
